// File: rtl/gate_scan_sequencer.sv
`timescale 1ns/1ps
// Self-test sequencer for the 2-input universal-gate unit: walks {a,b} through
// 00..11, captures NAND/NOR truth tables and flags pass/fail.
// Optional: define GATE_SCAN_ERR_CNT_EN to add a saturating failed-scan counter (err_cnt).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; a=b=0, busy=0
// ST_DRIVE | holding {a,b}=index for SETTLE_CYCLES, capturing at the end
// ST_DONE  | one-cycle done pulse, pass/tables valid
module gate_scan_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       g_nand,
    input  logic       g_nor,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] nand_tt,
    output logic [3:0] nor_tt
`ifdef GATE_SCAN_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("gate_scan_sequencer: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] NAND_EXP    = 4'b0111;
    localparam logic [3:0] NOR_EXP     = 4'b0001;

    state_t     state;
    logic [3:0] settle_cnt;
    logic [1:0] index;
    logic       settle_hit;
    logic       last_index;
    logic [3:0] nand_next;
    logic [3:0] nor_next;
    logic       scan_ok;

    assign settle_hit = (settle_cnt == SETTLE_LAST);
    assign last_index = (index == 2'd3);

    // Tables as they will look after this edge's capture; pass must see bit 3.
    always_comb begin
        nand_next        = nand_tt;
        nor_next         = nor_tt;
        nand_next[index] = g_nand;
        nor_next[index]  = g_nor;
    end

    assign scan_ok = (nand_next == NAND_EXP) && (nor_next == NOR_EXP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= 4'd0;
            index      <= 2'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            nand_tt    <= 4'd0;
            nor_tt     <= 4'd0;
`ifdef GATE_SCAN_ERR_CNT_EN
            err_cnt    <= 8'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    a    <= 1'b0;
                    b    <= 1'b0;
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        state      <= ST_DRIVE;
                        busy       <= 1'b1;
                        index      <= 2'd0;
                        settle_cnt <= 4'd0;
                        nand_tt    <= 4'd0;
                        nor_tt     <= 4'd0;
                    end
                end

                ST_DRIVE: begin
                    if (settle_hit) begin
                        nand_tt    <= nand_next;
                        nor_tt     <= nor_next;
                        settle_cnt <= 4'd0;
                        if (last_index) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            a     <= 1'b0;
                            b     <= 1'b0;
                            pass  <= scan_ok;
`ifdef GATE_SCAN_ERR_CNT_EN
                            if (!scan_ok && err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
`endif
                        end else begin
                            index  <= index + 2'd1;
                            {a, b} <= index + 2'd1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    a     <= 1'b0;
                    b     <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    a     <= 1'b0;
                    b     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_scan_sequencer.sv
`timescale 1ns/1ps
// Directed bench for gate_scan_sequencer: one S=1 and one S=3 instance, each
// driven by a behavioural gate unit (NAND optionally stuck at 1 on the S=1 side).
module tb_gate_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic rst1 = 1'b1, start1 = 1'b0, fault1 = 1'b0;
    logic a1, b1, busy1, done1, pass1, g_nand1, g_nor1;
    logic [3:0] nand_tt1, nor_tt1;

    logic rst3 = 1'b1, start3 = 1'b0;
    logic a3, b3, busy3, done3, pass3, g_nand3, g_nor3;
    logic [3:0] nand_tt3, nor_tt3;

`ifdef GATE_SCAN_ERR_CNT_EN
    logic [7:0] err_cnt1, err_cnt3;
`endif

    assign g_nand1 = fault1 ? 1'b1 : ~(a1 & b1);
    assign g_nor1  = ~(a1 | b1);
    assign g_nand3 = ~(a3 & b3);
    assign g_nor3  = ~(a3 | b3);

    gate_scan_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .g_nand(g_nand1), .g_nor(g_nor1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .nand_tt(nand_tt1), .nor_tt(nor_tt1)
`ifdef GATE_SCAN_ERR_CNT_EN
        , .err_cnt(err_cnt1)
`endif
    );

    gate_scan_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .g_nand(g_nand3), .g_nor(g_nor3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
        .nand_tt(nand_tt3), .nor_tt(nor_tt3)
`ifdef GATE_SCAN_ERR_CNT_EN
        , .err_cnt(err_cnt3)
`endif
    );

    task automatic test_reset();
        #2;
        total++; if ({a1, b1, busy1, done1, pass1} !== 5'b0) begin bad++;
            $display("FAIL reset_ctl1 got %b want 00000", {a1, b1, busy1, done1, pass1}); end
        total++; if ({nand_tt1, nor_tt1} !== 8'h00) begin bad++;
            $display("FAIL reset_tt1 got %h want 00", {nand_tt1, nor_tt1}); end
        total++; if ({a3, b3, busy3, done3, pass3, nand_tt3, nor_tt3} !== 13'b0) begin bad++;
            $display("FAIL reset_all3 got %b want 0", {a3, b3, busy3, done3, pass3, nand_tt3, nor_tt3}); end
`ifdef GATE_SCAN_ERR_CNT_EN
        total++; if (err_cnt1 !== 8'h00) begin bad++;
            $display("FAIL reset_err_cnt got %h want 00", err_cnt1); end
`endif
        @(negedge clk);
        rst1 = 1'b0;
        rst3 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total++; if ({a1, b1, busy1, done1, pass1, nand_tt1, nor_tt1} !== 13'b0) begin bad++;
                $display("FAIL idle1 cycle%0d got %b want 0", j, {a1, b1, busy1, done1, pass1, nand_tt1, nor_tt1}); end
            total++; if ({a3, b3, busy3, done3} !== 4'b0) begin bad++;
                $display("FAIL idle3 cycle%0d got %b want 0000", j, {a3, b3, busy3, done3}); end
        end
    endtask

    task automatic test_good();
        logic [1:0] exp_ab;
        @(negedge clk);
        start1 = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            start1 = 1'b0;
            exp_ab = (j < 4) ? 2'(j) : 2'd0;
            total++; if ({a1, b1} !== exp_ab) begin bad++;
                $display("FAIL good_ab edge%0d got %b want %b", j, {a1, b1}, exp_ab); end
            total++; if (done1 !== (j == 4)) begin bad++;
                $display("FAIL good_done edge%0d got %b want %b", j, done1, (j == 4)); end
            total++; if (busy1 !== (j < 4)) begin bad++;
                $display("FAIL good_busy edge%0d got %b want %b", j, busy1, (j < 4)); end
        end
        total++; if (nand_tt1 !== 4'b0111) begin bad++;
            $display("FAIL good_nand_tt got %b want 0111", nand_tt1); end
        total++; if (nor_tt1 !== 4'b0001) begin bad++;
            $display("FAIL good_nor_tt got %b want 0001", nor_tt1); end
        total++; if (pass1 !== 1'b1) begin bad++;
            $display("FAIL good_pass got %b want 1", pass1); end
    endtask

    task automatic test_fault();
        fault1 = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        total++; if (pass1 !== 1'b1) begin bad++;
            $display("FAIL fault_pass_hold got %b want 1", pass1); end
        total++; if (nand_tt1 !== 4'b0000) begin bad++;
            $display("FAIL fault_tt_clear got %b want 0000", nand_tt1); end
        repeat (4) @(negedge clk);
        total++; if (done1 !== 1'b1) begin bad++;
            $display("FAIL fault_done got %b want 1", done1); end
        total++; if (nand_tt1 !== 4'b1111) begin bad++;
            $display("FAIL fault_nand_tt got %b want 1111", nand_tt1); end
        total++; if (nor_tt1 !== 4'b0001) begin bad++;
            $display("FAIL fault_nor_tt got %b want 0001", nor_tt1); end
        total++; if (pass1 !== 1'b0) begin bad++;
            $display("FAIL fault_pass got %b want 0", pass1); end
`ifdef GATE_SCAN_ERR_CNT_EN
        total++; if (err_cnt1 !== 8'd1) begin bad++;
            $display("FAIL fault_err_cnt got %0d want 1", err_cnt1); end
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            repeat (5) @(negedge clk);
        end
        total++; if (err_cnt1 !== 8'hFF) begin bad++;
            $display("FAIL err_cnt_sat got %h want ff", err_cnt1); end
`endif
        fault1 = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start1 = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (j == 11) start1 = 1'b0;
            total++; if (done1 !== (j == 4 || j == 10)) begin bad++;
                $display("FAIL b2b_done edge%0d got %b want %b", j, done1, (j == 4 || j == 10)); end
            total++; if (busy1 !== (j < 4 || (j >= 6 && j < 10))) begin bad++;
                $display("FAIL b2b_busy edge%0d got %b want %b", j, busy1, (j < 4 || (j >= 6 && j < 10))); end
        end
        total++; if ({pass1, nand_tt1, nor_tt1} !== 9'b1_0111_0001) begin bad++;
            $display("FAIL b2b_result got %b want 101110001", {pass1, nand_tt1, nor_tt1}); end
    endtask

    task automatic test_settle3();
        int dones;
        logic [1:0] exp_ab;
        logic [3:0] exp_nand;
        dones = 0;
        @(negedge clk);
        start3 = 1'b1;
        for (int j = 0; j < 21; j++) begin
            @(negedge clk);
            start3 = ((j + 1) == 2 || (j + 1) == 7 || (j + 1) == 13);
            if (done3 === 1'b1) dones++;
            exp_ab   = (j < 12) ? 2'(j / 3) : 2'd0;
            exp_nand = (j < 3) ? 4'b0000 : (j < 6) ? 4'b0001 : (j < 9) ? 4'b0011 : 4'b0111;
            total++; if ({a3, b3} !== exp_ab) begin bad++;
                $display("FAIL s3_ab edge%0d got %b want %b", j, {a3, b3}, exp_ab); end
            total++; if (nand_tt3 !== exp_nand) begin bad++;
                $display("FAIL s3_nand_tt edge%0d got %b want %b", j, nand_tt3, exp_nand); end
            total++; if (nor_tt3 !== ((j < 3) ? 4'b0000 : 4'b0001)) begin bad++;
                $display("FAIL s3_nor_tt edge%0d got %b", j, nor_tt3); end
            total++; if (busy3 !== (j < 12)) begin bad++;
                $display("FAIL s3_busy edge%0d got %b want %b", j, busy3, (j < 12)); end
            total++; if (done3 !== (j == 12)) begin bad++;
                $display("FAIL s3_done edge%0d got %b want %b", j, done3, (j == 12)); end
        end
        total++; if (dones != 1) begin bad++;
            $display("FAIL s3_done_count got %0d want 1", dones); end
        total++; if (pass3 !== 1'b1) begin bad++;
            $display("FAIL s3_pass got %b want 1", pass3); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        total++; if ({a1, b1, busy1} !== 3'b011) begin bad++;
            $display("FAIL rmid_pre got %b want 011", {a1, b1, busy1}); end
        rst1 = 1'b1;
        #1;
        total++; if ({a1, b1, busy1, done1, pass1} !== 5'b0) begin bad++;
            $display("FAIL rmid_ctl got %b want 00000", {a1, b1, busy1, done1, pass1}); end
        total++; if ({nand_tt1, nor_tt1} !== 8'h00) begin bad++;
            $display("FAIL rmid_tt got %h want 00", {nand_tt1, nor_tt1}); end
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            total++; if ({busy1, done1} !== 2'b00) begin bad++;
                $display("FAIL rmid_quiet cycle%0d got %b want 00", j, {busy1, done1}); end
        end
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        total++; if ({done1, pass1} !== 2'b11) begin bad++;
            $display("FAIL rmid_rescan got %b want 11", {done1, pass1}); end
        total++; if ({nand_tt1, nor_tt1} !== 8'b0111_0001) begin bad++;
            $display("FAIL rmid_rescan_tt got %b want 01110001", {nand_tt1, nor_tt1}); end
    endtask

    initial begin
        test_reset();
        test_good();
        test_fault();
        test_back_to_back();
        test_settle3();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
